// File: rtl/gpio_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_cmd_decoder
//  Description : Decodes 32-bit command words delivered as 1-cycle strobes
//                from the GPIO CDC bridge. It maintains double-buffered
//                channel registers (shadow -> active), a commit strobe, a
//                counted trigger pulse, a command counter and sticky error
//                flags. Everything runs in the data clock domain.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_cmd_decoder #(
  parameter int NUM_CH = 8,   // number of channels, 1..16
  parameter int DATA_W = 16   // channel register width, 1..24
) (
  input  logic                     dst_clk,
  input  logic                     dst_rst_n,
  input  logic                     wen_dst,
  input  logic [31:0]              wdata_dst,
  output logic [NUM_CH*DATA_W-1:0] active_flat,
  output logic                     commit_stb,
  output logic                     trig_out,
  output logic                     trig_busy,
  output logic [15:0]              cmd_count,
  output logic [2:0]               err_flags
);

  // --------------------------------------------------------------------------
  // Opcodes and error bit positions
  // --------------------------------------------------------------------------
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_COMMIT = 4'h2;
  localparam logic [3:0] OP_CLEAR  = 4'h3;
  localparam logic [3:0] OP_PULSE  = 4'h4;
  localparam logic [3:0] OP_CLRERR = 4'hF;

  localparam int ERR_BAD_OP = 0;
  localparam int ERR_BAD_CH = 1;
  localparam int ERR_BUSY   = 2;

  // Channel numbers are 4 bits wide; compare with one spare bit so that
  // NUM_CH = 16 is representable.
  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

  // --------------------------------------------------------------------------
  // Trigger state machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } trig_state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] shadow_d [NUM_CH];
  logic [DATA_W-1:0] active_q [NUM_CH];
  logic [DATA_W-1:0] active_d [NUM_CH];

  logic              commit_stb_q;
  logic              commit_stb_d;
  logic [15:0]       cmd_count_q;
  logic [15:0]       cmd_count_d;
  logic [2:0]        err_q;
  logic [2:0]        err_d;

  trig_state_e       state_q;
  trig_state_e       state_d;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;

  // --------------------------------------------------------------------------
  // Command word fields
  // --------------------------------------------------------------------------
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_ch;
  logic [23:0] cmd_payload;
  logic [15:0] cmd_len;
  logic        cmd_ch_ok;

  assign cmd_op      = wdata_dst[31:28];
  assign cmd_ch      = wdata_dst[27:24];
  assign cmd_payload = wdata_dst[23:0];
  assign cmd_len     = cmd_payload[15:0];
  assign cmd_ch_ok   = ({1'b0, cmd_ch} < NUM_CH_W);

  // Not every payload bit feeds logic for every parameter set; fold the word
  // into one otherwise-unused bit so narrow configurations stay warning-free.
  logic unused_word_bits;
  assign unused_word_bits = ^wdata_dst;

  // --------------------------------------------------------------------------
  // Next-state logic: trigger countdown first, then the decoded command.
  // A PULSE is only accepted from IDLE, so the two never fight over state_d.
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    commit_stb_d = 1'b0;
    cmd_count_d  = cmd_count_q;
    err_d        = err_q;
    state_d      = state_q;
    cnt_d        = cnt_q;

    // Trigger countdown: len high cycles, leave RUN after the last one.
    if (state_q == ST_RUN) begin
      if (cnt_q == 16'd0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    if (wen_dst) begin
      cmd_count_d = cmd_count_q + 16'd1;

      case (cmd_op)
        OP_NOP: begin
        end

        OP_WRITE: begin
          if (cmd_ch_ok) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (cmd_ch == 4'(k)) begin
                shadow_d[k] = cmd_payload[DATA_W-1:0];
              end
            end
          end else begin
            err_d[ERR_BAD_CH] = 1'b1;
          end
        end

        OP_COMMIT: begin
          // Mask bits at or above NUM_CH are simply never looked at.
          for (int k = 0; k < NUM_CH; k++) begin
            if (cmd_payload[k]) begin
              active_d[k] = shadow_q[k];
            end
          end
          commit_stb_d = 1'b1;
        end

        OP_CLEAR: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (cmd_payload[k]) begin
              shadow_d[k] = '0;
              active_d[k] = '0;
            end
          end
        end

        OP_PULSE: begin
          if (state_q == ST_RUN) begin
            err_d[ERR_BUSY] = 1'b1;
          end else if (cmd_len != 16'd0) begin
            state_d = ST_RUN;
            cnt_d   = cmd_len - 16'd1;
          end
        end

        OP_CLRERR: begin
          err_d = 3'b000;
        end

        default: begin
          err_d[ERR_BAD_OP] = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register update with synchronous active-low reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge dst_clk) begin
    if (!dst_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      commit_stb_q <= 1'b0;
      cmd_count_q  <= 16'd0;
      err_q        <= 3'b000;
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      commit_stb_q <= commit_stb_d;
      cmd_count_q  <= cmd_count_d;
      err_q        <= err_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all taken straight from flops.
  // --------------------------------------------------------------------------
  genvar gk;
  generate
    for (gk = 0; gk < NUM_CH; gk++) begin : g_flat
      assign active_flat[gk*DATA_W +: DATA_W] = active_q[gk];
    end
  endgenerate

  assign commit_stb = commit_stb_q;
  assign trig_out   = (state_q == ST_RUN);
  assign trig_busy  = (state_q == ST_RUN);
  assign cmd_count  = cmd_count_q;
  assign err_flags  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_cmd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gpio_cmd_decoder
//  Description : Directed bench for gpio_cmd_decoder. A behavioural model
//                predicts every output per cycle; predictions are queued when
//                a cycle is driven and popped when that cycle's outputs land.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_cmd_decoder;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 16;
  localparam int FW     = NUM_CH * DATA_W;

  logic          dst_clk;
  logic          dst_rst_n;
  logic          wen_dst;
  logic [31:0]   wdata_dst;
  logic [FW-1:0] active_flat;
  logic          commit_stb;
  logic          trig_out;
  logic          trig_busy;
  logic [15:0]   cmd_count;
  logic [2:0]    err_flags;

  gpio_cmd_decoder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .dst_clk     (dst_clk),
    .dst_rst_n   (dst_rst_n),
    .wen_dst     (wen_dst),
    .wdata_dst   (wdata_dst),
    .active_flat (active_flat),
    .commit_stb  (commit_stb),
    .trig_out    (trig_out),
    .trig_busy   (trig_busy),
    .cmd_count   (cmd_count),
    .err_flags   (err_flags)
  );

  initial dst_clk = 1'b0;
  always #5 dst_clk = ~dst_clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [FW-1:0] act;
    logic          commit;
    logic          trig;
    logic [15:0]   cnt;
    logic [2:0]    err;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  logic [DATA_W-1:0] m_sh  [NUM_CH];
  logic [DATA_W-1:0] m_act [NUM_CH];
  logic [15:0]       m_cnt;
  logic [2:0]        m_err;
  logic              m_commit;
  int                m_rem;   // trigger high cycles still to come

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ch, input logic [23:0] pl);
    return {op, ch, pl};
  endfunction

  // Drive one cycle, predict its outcome, then check the outputs after the edge.
  task automatic step(input logic rst_n_i, input logic wen_i, input logic [31:0] word);
    exp_t e;
    exp_t got;
    logic busy;
    int   ch;
    @(negedge dst_clk);
    dst_rst_n = rst_n_i;
    wen_dst   = wen_i;
    wdata_dst = word;

    m_commit = 1'b0;
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_sh[k]  = '0;
        m_act[k] = '0;
      end
      m_cnt = 16'd0;
      m_err = 3'b000;
      m_rem = 0;
    end else begin
      busy = (m_rem > 0);
      if (m_rem > 0) m_rem--;
      if (wen_i) begin
        m_cnt = m_cnt + 16'd1;
        ch = int'(word[27:24]);
        case (word[31:28])
          4'h0: ;
          4'h1: if (ch < NUM_CH) m_sh[ch] = word[DATA_W-1:0]; else m_err[1] = 1'b1;
          4'h2: begin
            for (int k = 0; k < NUM_CH; k++) if (word[k]) m_act[k] = m_sh[k];
            m_commit = 1'b1;
          end
          4'h3: for (int k = 0; k < NUM_CH; k++) if (word[k]) begin m_sh[k] = '0; m_act[k] = '0; end
          4'h4: begin
            if (busy) m_err[2] = 1'b1;
            else if (word[15:0] != 16'd0) m_rem = int'(word[15:0]);
          end
          4'hF: m_err = 3'b000;
          default: m_err[0] = 1'b1;
        endcase
      end
    end

    for (int k = 0; k < NUM_CH; k++) e.act[k*DATA_W +: DATA_W] = m_act[k];
    e.commit = m_commit;
    e.trig   = (m_rem > 0);
    e.cnt    = m_cnt;
    e.err    = m_err;
    exp_q.push_back(e);

    @(posedge dst_clk);
    #1;
    got = exp_q.pop_front();
    chk("active_flat", active_flat, got.act);
    chk("commit_stb",  FW'(commit_stb), FW'(got.commit));
    chk("trig_out",    FW'(trig_out),   FW'(got.trig));
    chk("trig_busy",   FW'(trig_busy),  FW'(got.trig));
    chk("cmd_count",   FW'(cmd_count),  FW'(got.cnt));
    chk("err_flags",   FW'(err_flags),  FW'(got.err));
  endtask

  task automatic cmd(input logic [31:0] word);
    step(1'b1, 1'b1, word);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  // Guard against a stuck simulation.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dst_rst_n = 1'b0;
    wen_dst   = 1'b0;
    wdata_dst = 32'h0;

    // Reset state
    do_reset(2);
    chk("rst_active_zero", active_flat, '0);

    // Double-buffered write / commit
    cmd(mk(4'h1, 4'd2, 24'h001234));
    cmd(mk(4'h1, 4'd5, 24'h00BEEF));
    chk("active_before_commit", active_flat, '0);
    cmd(mk(4'h2, 4'd0, 24'h000024));
    chk("ch2_after_commit", FW'(active_flat[2*DATA_W +: DATA_W]), FW'(16'h1234));
    chk("ch5_after_commit", FW'(active_flat[5*DATA_W +: DATA_W]), FW'(16'hBEEF));
    chk("count_after_three", FW'(cmd_count), FW'(16'd3));
    idle(1);

    // PULSE len=5 with a rejected PULSE two cycles later, then CLRERR
    cmd(mk(4'h4, 4'd0, 24'h000005));
    idle(1);
    cmd(mk(4'h4, 4'd0, 24'h000005));
    chk("busy_err", FW'(err_flags), FW'(3'b100));
    idle(4);
    cmd(mk(4'hF, 4'd0, 24'h0));
    chk("clrerr", FW'(err_flags), FW'(3'b000));

    // Back-to-back WRITE, COMMIT, CLEAR, NOP
    cmd(mk(4'h1, 4'd0, 24'h00000A));
    cmd(mk(4'h2, 4'd0, 24'h000001));
    chk("ch0_committed", FW'(active_flat[DATA_W-1:0]), FW'(16'h000A));
    cmd(mk(4'h3, 4'd0, 24'h000001));
    chk("ch0_cleared", FW'(active_flat[DATA_W-1:0]), FW'(16'h0000));
    cmd(mk(4'h0, 4'd0, 24'h0));
    idle(1);

    // Error sources
    cmd(mk(4'h7, 4'd0, 24'h0));
    cmd(mk(4'h1, 4'd12, 24'h005555));
    chk("err_bits_01", FW'(err_flags), FW'(3'b011));
    cmd(mk(4'hF, 4'd0, 24'h0));

    // Payload truncation and out-of-range commit mask bits
    cmd(mk(4'h1, 4'd1, 24'hFFFFFF));
    cmd(mk(4'h2, 4'd3, 24'h00FF02));
    chk("ch1_truncated", FW'(active_flat[DATA_W +: DATA_W]), FW'(16'hFFFF));
    cmd(mk(4'h2, 4'd0, 24'h000000));

    // PULSE on the edge that ends a pulse is rejected; next one accepted
    cmd(mk(4'h4, 4'd0, 24'h000003));
    idle(2);
    cmd(mk(4'h4, 4'd0, 24'h000003));
    cmd(mk(4'h4, 4'd0, 24'h000002));
    idle(3);
    cmd(mk(4'h4, 4'd0, 24'h000001));
    idle(2);

    // Reset in the middle of a long pulse
    cmd(mk(4'h4, 4'd0, 24'h000064));
    idle(10);
    do_reset(3);
    chk("trig_after_rst", FW'(trig_out), FW'(1'b0));
    idle(2);

    // Counter wrap and zero-length pulse
    for (int i = 0; i < 65536; i++) cmd(mk(4'h0, 4'd0, 24'h0));
    chk("count_wrapped", FW'(cmd_count), FW'(16'h0000));
    cmd(mk(4'h4, 4'd0, 24'h000000));
    idle(2);
    chk("len0_no_err", FW'(err_flags), FW'(3'b000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
